// File: rtl/stream_traffic_gen.sv
`default_nettype none
// stream_traffic_gen rev 1.0: programmable valid/last/data source with fixed bubbles and inter-stream gaps.
// Define STREAM_TRAFFIC_GEN_LFSR_EN to replace the incrementing payload with a 64-bit Galois LFSR.
module stream_traffic_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [63:0] LFSR_SEED  = 64'h1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_beats,
  input  logic [CNT_WIDTH-1:0]  cfg_streams,
  input  logic [CNT_WIDTH-1:0]  cfg_bubble,
  input  logic [CNT_WIDTH-1:0]  cfg_idle,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           beats_sent
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_BUBBLE = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_beats, w_beats_nxt;
  logic [CNT_WIDTH-1:0] r_streams, w_streams_nxt;
  logic [CNT_WIDTH-1:0] r_bubble, w_bubble_nxt;
  logic [CNT_WIDTH-1:0] r_idle, w_idle_nxt;
  logic [CNT_WIDTH-1:0] r_beat_idx, w_beat_idx_nxt;
  logic [CNT_WIDTH-1:0] r_stream_idx, w_stream_idx_nxt;
  logic [CNT_WIDTH-1:0] r_wait, w_wait_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_last, w_last_nxt;
  logic                 r_final, w_final_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [63:0]          r_sent, w_sent_nxt;
  logic [CNT_WIDTH-1:0] w_last_idx;
  logic                 w_load, w_adv;

  assign w_last_idx = r_beats - CNT_WIDTH'(1);
  assign w_load     = (r_state == S_IDLE) && start;
  assign w_adv      = (r_state == S_SEND) && r_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_beats      <= '0;
      r_streams    <= '0;
      r_bubble     <= '0;
      r_idle       <= '0;
      r_beat_idx   <= '0;
      r_stream_idx <= '0;
      r_wait       <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_final      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sent       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_beats      <= w_beats_nxt;
      r_streams    <= w_streams_nxt;
      r_bubble     <= w_bubble_nxt;
      r_idle       <= w_idle_nxt;
      r_beat_idx   <= w_beat_idx_nxt;
      r_stream_idx <= w_stream_idx_nxt;
      r_wait       <= w_wait_nxt;
      r_valid      <= w_valid_nxt;
      r_last       <= w_last_nxt;
      r_final      <= w_final_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_sent       <= w_sent_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_beats_nxt      = r_beats;
    w_streams_nxt    = r_streams;
    w_bubble_nxt     = r_bubble;
    w_idle_nxt       = r_idle;
    w_beat_idx_nxt   = r_beat_idx;
    w_stream_idx_nxt = r_stream_idx;
    w_wait_nxt       = r_wait;
    w_valid_nxt      = r_valid;
    w_last_nxt       = r_last;
    w_final_nxt      = r_final;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_sent_nxt       = r_sent;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_beats_nxt   = cfg_beats;
          w_streams_nxt = cfg_streams;
          w_bubble_nxt  = cfg_bubble;
          w_idle_nxt    = cfg_idle;
          w_sent_nxt    = '0;
          if (cfg_beats == '0 || cfg_streams == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt      = S_SEND;
            w_valid_nxt      = 1'b1;
            w_busy_nxt       = 1'b1;
            w_last_nxt       = (cfg_beats == CNT_WIDTH'(1));
            w_final_nxt      = (cfg_streams == CNT_WIDTH'(1));
            w_beat_idx_nxt   = '0;
            w_stream_idx_nxt = '0;
          end
        end
      end
      S_SEND: begin
        if (w_adv) begin
          w_sent_nxt = r_sent + 64'd1;
          if (!r_last) begin
            w_beat_idx_nxt = r_beat_idx + CNT_WIDTH'(1);
            if (r_bubble != '0) begin
              w_state_nxt = S_BUBBLE;
              w_wait_nxt  = r_bubble - CNT_WIDTH'(1);
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
            end else begin
              w_last_nxt = (r_beat_idx + CNT_WIDTH'(1) == w_last_idx);
            end
          end else if (r_final) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_stream_idx_nxt = r_stream_idx + CNT_WIDTH'(1);
            w_final_nxt      = (r_stream_idx + CNT_WIDTH'(1) == r_streams - CNT_WIDTH'(1));
            w_beat_idx_nxt   = '0;
            if (r_idle != '0) begin
              w_state_nxt = S_GAP;
              w_wait_nxt  = r_idle - CNT_WIDTH'(1);
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
            end else begin
              w_last_nxt = (r_beats == CNT_WIDTH'(1));
            end
          end
        end
      end
      S_BUBBLE, S_GAP: begin
        // m_last is parked low while valid is low and recomputed on re-entry
        if (r_wait == '0) begin
          w_state_nxt = S_SEND;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (r_beat_idx == w_last_idx);
        end else begin
          w_wait_nxt = r_wait - CNT_WIDTH'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef STREAM_TRAFFIC_GEN_LFSR_EN
  logic [63:0] r_lfsr;
  logic [63:0] w_lfsr_step;

  assign w_lfsr_step = {1'b0, r_lfsr[63:1]} ^ (r_lfsr[0] ? 64'hD800_0000_0000_0000 : 64'h0);

  always_ff @(posedge clk) begin
    if (!rst_n)      r_lfsr <= LFSR_SEED;
    else if (w_load) r_lfsr <= LFSR_SEED;
    else if (w_adv)  r_lfsr <= w_lfsr_step;
  end

  assign m_data = r_lfsr[DATA_WIDTH-1:0];
`else
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_data <= '0;
    else if (w_load) r_data <= '0;
    else if (w_adv)  r_data <= r_data + DATA_WIDTH'(1);
  end

  assign m_data = r_data;
`endif

  assign m_valid    = r_valid;
  assign m_last     = r_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign beats_sent = r_sent;
  assign stop       = r_valid & r_last & r_final;

endmodule
`default_nettype wire
